// File: rtl/fft_butterfly_pipe_if.sv
// Bus between the per-layer address sequencer / sample RAM / twiddle ROM and the
// radix-2 butterfly datapath. The slave modport is the butterfly side.
interface fft_butterfly_pipe_if #(
  parameter int DATA_WIDTH = 16,
  parameter int TW_WIDTH   = 16,
  parameter int ADDR_SIZE  = 5
);
  logic                         i_valid;
  logic [ADDR_SIZE-1:0]         i_rdaddr_A;
  logic [ADDR_SIZE-1:0]         i_rdaddr_B;
  logic signed [DATA_WIDTH-1:0] i_A_re;
  logic signed [DATA_WIDTH-1:0] i_A_im;
  logic signed [DATA_WIDTH-1:0] i_B_re;
  logic signed [DATA_WIDTH-1:0] i_B_im;
  logic signed [TW_WIDTH-1:0]   i_tw_re;
  logic signed [TW_WIDTH-1:0]   i_tw_im;

  logic                         o_wren;
  logic [ADDR_SIZE-1:0]         o_wraddr_A;
  logic [ADDR_SIZE-1:0]         o_wraddr_B;
  logic signed [DATA_WIDTH-1:0] o_A_re;
  logic signed [DATA_WIDTH-1:0] o_A_im;
  logic signed [DATA_WIDTH-1:0] o_B_re;
  logic signed [DATA_WIDTH-1:0] o_B_im;
  logic                         o_busy;

  modport master (
    output i_valid, i_rdaddr_A, i_rdaddr_B,
    output i_A_re, i_A_im, i_B_re, i_B_im, i_tw_re, i_tw_im,
    input  o_wren, o_wraddr_A, o_wraddr_B,
    input  o_A_re, o_A_im, o_B_re, o_B_im, o_busy
  );

  modport slave (
    input  i_valid, i_rdaddr_A, i_rdaddr_B,
    input  i_A_re, i_A_im, i_B_re, i_B_im, i_tw_re, i_tw_im,
    output o_wren, o_wraddr_A, o_wraddr_B,
    output o_A_re, o_A_im, o_B_re, o_B_im, o_busy
  );
endinterface

// File: rtl/fft_butterfly_pipe.sv
// Three-stage radix-2 butterfly: A' = A + W*B, B' = A - W*B, one per clock.
// Define FFT_BFLY_SCALE_EN to halve both results (round half up) before saturation.
module fft_butterfly_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int TW_WIDTH   = 16,
  parameter int ADDR_SIZE  = 5
) (
  input logic                 i_CLK,
  input logic                 i_RST,
  fft_butterfly_pipe_if.slave bus
);
  localparam int MW = DATA_WIDTH + TW_WIDTH;
  localparam int PW = DATA_WIDTH + TW_WIDTH + 1;
  localparam int SW = DATA_WIDTH + 2;

  localparam logic signed [PW-1:0] RND  = {{(PW-TW_WIDTH+1){1'b0}}, 1'b1, {(TW_WIDTH-2){1'b0}}};
  localparam logic signed [SW-1:0] SMAX = {3'b000, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN = {3'b111, {(DATA_WIDTH-1){1'b0}}};

  // Index 0 is the real lane, index 1 the imaginary lane.
  logic                         v0_q, v1_q, v2_q;
  logic [ADDR_SIZE-1:0]         addr_a0_q, addr_b0_q;
  logic [ADDR_SIZE-1:0]         addr_a1_q, addr_b1_q;
  logic [ADDR_SIZE-1:0]         addr_a2_q, addr_b2_q;
  logic signed [DATA_WIDTH-1:0] a_in [2];
  logic signed [DATA_WIDTH-1:0] b_in [2];
  logic signed [TW_WIDTH-1:0]   w_in [2];
  logic signed [MW-1:0]         m_rr, m_ii, m_ri, m_ir;
  logic signed [PW-1:0]         p_full [2];
  logic signed [DATA_WIDTH:0]   p1_d [2];
  logic signed [DATA_WIDTH:0]   p1_q [2];
  logic signed [DATA_WIDTH-1:0] a1_q [2];
  logic signed [DATA_WIDTH-1:0] s2_d [2];
  logic signed [DATA_WIDTH-1:0] d2_d [2];
  logic signed [DATA_WIDTH-1:0] s2_q [2];
  logic signed [DATA_WIDTH-1:0] d2_q [2];

  function automatic logic signed [DATA_WIDTH-1:0] sat_scale(input logic signed [SW-1:0] x);
    logic signed [SW-1:0] y;
`ifdef FFT_BFLY_SCALE_EN
    y = x + SW'(1);
    y = y >>> 1;
`else
    y = x;
`endif
    if (y > SMAX) begin
      y = SMAX;
    end else if (y < SMIN) begin
      y = SMIN;
    end
    return y[DATA_WIDTH-1:0];
  endfunction

  assign a_in[0] = bus.i_A_re;
  assign a_in[1] = bus.i_A_im;
  assign b_in[0] = bus.i_B_re;
  assign b_in[1] = bus.i_B_im;
  assign w_in[0] = bus.i_tw_re;
  assign w_in[1] = bus.i_tw_im;

  assign m_rr = MW'(b_in[0]) * MW'(w_in[0]);
  assign m_ii = MW'(b_in[1]) * MW'(w_in[1]);
  assign m_ri = MW'(b_in[0]) * MW'(w_in[1]);
  assign m_ir = MW'(b_in[1]) * MW'(w_in[0]);

  // Rounding offset is folded into the full-width sum so only one adder chain per lane.
  assign p_full[0] = {m_rr[MW-1], m_rr} - {m_ii[MW-1], m_ii} + RND;
  assign p_full[1] = {m_ri[MW-1], m_ri} + {m_ir[MW-1], m_ir} + RND;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      logic signed [SW-1:0] a_ext;
      logic signed [SW-1:0] p_ext;

      assign p1_d[gi] = (DATA_WIDTH+1)'(p_full[gi] >>> (TW_WIDTH-1));
      assign a_ext    = {{2{a1_q[gi][DATA_WIDTH-1]}}, a1_q[gi]};
      assign p_ext    = {p1_q[gi][DATA_WIDTH], p1_q[gi]};
      assign s2_d[gi] = sat_scale(a_ext + p_ext);
      assign d2_d[gi] = sat_scale(a_ext - p_ext);
    end
  endgenerate

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      v0_q      <= 1'b0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      addr_a0_q <= '0;
      addr_b0_q <= '0;
      addr_a1_q <= '0;
      addr_b1_q <= '0;
      addr_a2_q <= '0;
      addr_b2_q <= '0;
      for (int k = 0; k < 2; k++) begin
        a1_q[k] <= '0;
        p1_q[k] <= '0;
        s2_q[k] <= '0;
        d2_q[k] <= '0;
      end
    end else begin
      v0_q <= bus.i_valid;
      v1_q <= v0_q;
      v2_q <= v1_q;
      if (bus.i_valid) begin
        addr_a0_q <= bus.i_rdaddr_A;
        addr_b0_q <= bus.i_rdaddr_B;
      end
      // Stage registers only load behind a valid, so outputs hold between writes.
      if (v0_q) begin
        addr_a1_q <= addr_a0_q;
        addr_b1_q <= addr_b0_q;
        a1_q      <= a_in;
        p1_q      <= p1_d;
      end
      if (v1_q) begin
        addr_a2_q <= addr_a1_q;
        addr_b2_q <= addr_b1_q;
        s2_q      <= s2_d;
        d2_q      <= d2_d;
      end
    end
  end

  assign bus.o_wren     = v2_q;
  assign bus.o_busy     = v0_q | v1_q | v2_q;
  assign bus.o_wraddr_A = addr_a2_q;
  assign bus.o_wraddr_B = addr_b2_q;
  assign bus.o_A_re     = s2_q[0];
  assign bus.o_A_im     = s2_q[1];
  assign bus.o_B_re     = d2_q[0];
  assign bus.o_B_im     = d2_q[1];
endmodule

// File: tb/tb_fft_butterfly_pipe.sv
// Directed bench for fft_butterfly_pipe; expectations follow FFT_BFLY_SCALE_EN.
module tb_fft_butterfly_pipe;
  localparam int DW = 16;
  localparam int TW = 16;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  fft_butterfly_pipe_if #(.DATA_WIDTH(DW), .TW_WIDTH(TW), .ADDR_SIZE(AW)) bus ();

  fft_butterfly_pipe #(.DATA_WIDTH(DW), .TW_WIDTH(TW), .ADDR_SIZE(AW)) dut (
    .i_CLK (clk),
    .i_RST (rst),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_data(input int are, input int aim, input int bre, input int bim,
                            input int wre, input int wim);
    bus.i_A_re  = DW'(are);
    bus.i_A_im  = DW'(aim);
    bus.i_B_re  = DW'(bre);
    bus.i_B_im  = DW'(bim);
    bus.i_tw_re = TW'(wre);
    bus.i_tw_im = TW'(wim);
  endtask

  task automatic drive_junk();
    drive_data(12345, -4321, -7777, 31000, -20000, 9999);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wren"}, 32'(bus.o_wren), 0);
    chk({tag, "_busy"}, 32'(bus.o_busy), 0);
    chk({tag, "_wraddrA"}, 32'(bus.o_wraddr_A), 0);
    chk({tag, "_wraddrB"}, 32'(bus.o_wraddr_B), 0);
    chk({tag, "_Are"}, 32'(bus.o_A_re), 0);
    chk({tag, "_Aim"}, 32'(bus.o_A_im), 0);
    chk({tag, "_Bre"}, 32'(bus.o_B_re), 0);
    chk({tag, "_Bim"}, 32'(bus.o_B_im), 0);
  endtask

  // One isolated butterfly: issue at c=0, data at c=1, result at c=3, held at c=4.
  task automatic bfly(input string tag, input int aa, input int ab,
                      input int are, input int aim, input int bre, input int bim,
                      input int wre, input int wim,
                      input int esr, input int esi, input int edr, input int edi);
    for (int c = 0; c < 5; c++) begin
      bus.i_valid    = (c == 0);
      bus.i_rdaddr_A = (c == 0) ? AW'(aa) : '0;
      bus.i_rdaddr_B = (c == 0) ? AW'(ab) : '0;
      if (c == 1) drive_data(are, aim, bre, bim, wre, wim);
      else        drive_junk();
      @(negedge clk);
      chk($sformatf("%s_wren_c%0d", tag, c), 32'(bus.o_wren), (c == 3) ? 1 : 0);
      chk($sformatf("%s_busy_c%0d", tag, c), 32'(bus.o_busy), (c >= 1 && c <= 3) ? 1 : 0);
      if (c == 3) begin
        $display("%s: wr A@%0d=(%0d,%0d) B@%0d=(%0d,%0d)", tag, bus.o_wraddr_A, bus.o_A_re,
                 bus.o_A_im, bus.o_wraddr_B, bus.o_B_re, bus.o_B_im);
        chk({tag, "_wraddrA"}, 32'(bus.o_wraddr_A), aa);
        chk({tag, "_wraddrB"}, 32'(bus.o_wraddr_B), ab);
        chk({tag, "_Are"}, 32'(bus.o_A_re), esr);
        chk({tag, "_Aim"}, 32'(bus.o_A_im), esi);
        chk({tag, "_Bre"}, 32'(bus.o_B_re), edr);
        chk({tag, "_Bim"}, 32'(bus.o_B_im), edi);
      end
      if (c == 4) begin
        chk({tag, "_hold_Are"}, 32'(bus.o_A_re), esr);
        chk({tag, "_hold_Bim"}, 32'(bus.o_B_im), edi);
      end
      @(posedge clk);
      #1;
    end
  endtask

`ifdef FFT_BFLY_SCALE_EN
  int stream_are [4] = '{0, 6, 11, 17};
  int stream_bim [4] = '{0, 0, -1, -1};
`else
  int stream_are [4] = '{0, 11, 22, 33};
  int stream_bim [4] = '{0, -1, -2, -3};
`endif

  initial begin
    rst = 1'b1;
    bus.i_valid    = 1'b0;
    bus.i_rdaddr_A = '0;
    bus.i_rdaddr_B = '0;
    drive_junk();

    // Reset values, then idle with i_valid low
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("idle_wren_c%0d", c), 32'(bus.o_wren), 0);
      @(posedge clk);
      #1;
    end

`ifdef FFT_BFLY_SCALE_EN
    bfly("unity",  0, 4, 1000, 0, 500, 0, 32767, 0,        750, 0, 250, 0);
    bfly("minus_j", 1, 5, 0, 0, 100, 200, 0, -32768,      100, -50, -100, 50);
    bfly("sat_pos", 2, 6, 32767, 0, 32767, 0, 32767, 0,   32767, 0, 1, 0);
    bfly("sat_neg", 3, 7, -32768, 0, 32767, 0, -32768, 0, -32767, 0, 0, 0);
`else
    bfly("unity",  0, 4, 1000, 0, 500, 0, 32767, 0,        1500, 0, 500, 0);
    bfly("minus_j", 1, 5, 0, 0, 100, 200, 0, -32768,      200, -100, -200, 100);
    bfly("sat_pos", 2, 6, 32767, 0, 32767, 0, 32767, 0,   32767, 0, 1, 0);
    bfly("sat_neg", 3, 7, -32768, 0, 32767, 0, -32768, 0, -32768, 0, -1, 0);
`endif

    // Four back-to-back issues: A=(10k,-k), B=(k,0), W=(32767,0) -> P=(k,0)
    for (int c = 0; c < 8; c++) begin
      bus.i_valid    = (c < 4);
      bus.i_rdaddr_A = (c < 4) ? AW'(c) : '0;
      bus.i_rdaddr_B = (c < 4) ? AW'(c + 4) : '0;
      if (c >= 1 && c <= 4) drive_data(10 * (c - 1), -(c - 1), c - 1, 0, 32767, 0);
      else                  drive_junk();
      @(negedge clk);
      chk($sformatf("stream_wren_c%0d", c), 32'(bus.o_wren), (c >= 3 && c <= 6) ? 1 : 0);
      chk($sformatf("stream_busy_c%0d", c), 32'(bus.o_busy), (c >= 1 && c <= 6) ? 1 : 0);
      if (c >= 3 && c <= 6) begin
        $display("stream[%0d]: wr A@%0d=(%0d,%0d) B@%0d=(%0d,%0d)", c - 3, bus.o_wraddr_A,
                 bus.o_A_re, bus.o_A_im, bus.o_wraddr_B, bus.o_B_re, bus.o_B_im);
        chk($sformatf("stream_wraddrA_%0d", c - 3), 32'(bus.o_wraddr_A), c - 3);
        chk($sformatf("stream_wraddrB_%0d", c - 3), 32'(bus.o_wraddr_B), c + 1);
        chk($sformatf("stream_Are_%0d", c - 3), 32'(bus.o_A_re), stream_are[c - 3]);
        chk($sformatf("stream_Bim_%0d", c - 3), 32'(bus.o_B_im), stream_bim[c - 3]);
      end
      @(posedge clk);
      #1;
    end

    // Reset pulsed while a butterfly is in flight; outputs are nonzero beforehand
    bus.i_valid    = 1'b1;
    bus.i_rdaddr_A = AW'(9);
    bus.i_rdaddr_B = AW'(13);
    @(posedge clk);
    #1;
    bus.i_valid    = 1'b0;
    bus.i_rdaddr_A = '0;
    bus.i_rdaddr_B = '0;
    drive_data(1000, 0, 500, 0, 32767, 0);
    #1;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    #1;
    rst = 1'b0;
    for (int c = 1; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("inflight_wren_c%0d", c), 32'(bus.o_wren), 0);
      chk($sformatf("inflight_busy_c%0d", c), 32'(bus.o_busy), 0);
      chk($sformatf("inflight_Are_c%0d", c), 32'(bus.o_A_re), 0);
      @(posedge clk);
      #1;
      drive_junk();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
